// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - programmable up-counter timer with prescaler and free-run/one-shot/periodic modes
module prog_timer #(
  parameter int WIDTH = 27,
  parameter int PRE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_period,
  input  logic [PRE_W-1:0] i_prescale,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tick,
  output logic             o_running,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_count, w_count_nxt;
  logic [PRE_W-1:0]   r_pre, w_pre_nxt;
  logic [1:0]         r_mode, w_mode_nxt;
  logic [WIDTH-1:0]   r_period, w_period_nxt;
  logic [PRE_W-1:0]   r_prescale, w_prescale_nxt;
  logic               r_tick, w_tick_nxt;
  logic               r_running, w_running_nxt;
  logic               r_done, w_done_nxt;

  logic w_adv;
  logic w_at_term;
  logic w_all_ones;

  // Count only advances on a prescaler match while running and not overridden by a control pulse.
  assign w_adv      = (r_state == S_RUN) & ~i_stop & ~i_start & ~i_clear & (r_pre == r_prescale);
  assign w_at_term  = (r_count == r_period);
  assign w_all_ones = &r_count;

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_pre_nxt      = r_pre;
    w_mode_nxt     = r_mode;
    w_period_nxt   = r_period;
    w_prescale_nxt = r_prescale;
    w_tick_nxt     = 1'b0;
    w_done_nxt     = r_done;

    if (i_clear) begin
      w_count_nxt = '0;
      w_pre_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_state_nxt = S_IDLE;
    end else if (i_start) begin
      w_mode_nxt     = i_mode;
      w_period_nxt   = i_period;
      w_prescale_nxt = i_prescale;
      w_count_nxt    = '0;
      w_pre_nxt      = '0;
      w_done_nxt     = 1'b0;
      w_state_nxt    = S_RUN;
    end else if (r_state == S_RUN && !i_stop) begin
      if (w_adv) begin
        w_pre_nxt = '0;
        case (r_mode)
          2'b01: begin
            if (w_at_term) begin
              w_tick_nxt  = 1'b1;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_count_nxt = r_count + WIDTH'(1);
            end
          end
          2'b10: begin
            if (w_at_term) begin
              w_count_nxt = '0;
              w_tick_nxt  = 1'b1;
            end else begin
              w_count_nxt = r_count + WIDTH'(1);
            end
          end
          default: begin
            // Mode 11 falls here and behaves as free-run.
            w_count_nxt = r_count + WIDTH'(1);
            w_tick_nxt  = w_all_ones;
          end
        endcase
      end else begin
        w_pre_nxt = r_pre + PRE_W'(1);
      end
    end

    w_running_nxt = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_pre      <= '0;
      r_mode     <= '0;
      r_period   <= '0;
      r_prescale <= '0;
      r_tick     <= 1'b0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_pre      <= w_pre_nxt;
      r_mode     <= w_mode_nxt;
      r_period   <= w_period_nxt;
      r_prescale <= w_prescale_nxt;
      r_tick     <= w_tick_nxt;
      r_running  <= w_running_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_count   = r_count;
  assign o_tick    = r_tick;
  assign o_running = r_running;
  assign o_done    = r_done;

endmodule
